// File: rtl/bilerp_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bilerp_pipe_if: neighbourhood input and pixel output handshake bundle.
// Revision 1.0
// ----------------------------------------------------------------------------
interface bilerp_pipe_if #(
  parameter int NUM_CH     = 3,
  parameter int CH_WIDTH   = 8,
  parameter int FRAC_WIDTH = 6
);
  localparam int PIX_W = NUM_CH * CH_WIDTH;

  logic                  in_valid;
  logic                  in_ready;
  logic [PIX_W-1:0]      p00;
  logic [PIX_W-1:0]      p01;
  logic [PIX_W-1:0]      p10;
  logic [PIX_W-1:0]      p11;
  logic [FRAC_WIDTH-1:0] u_frac;
  logic [FRAC_WIDTH-1:0] v_frac;
  logic                  x_edge;
  logic                  y_edge;
  logic                  mode;
  logic                  in_sol;
  logic                  in_eol;
  logic                  in_sof;
  logic                  out_valid;
  logic                  out_ready;
  logic [PIX_W-1:0]      out_data;
  logic                  out_sol;
  logic                  out_eol;
  logic                  out_sof;
  logic                  busy;

  modport master (
    output in_valid, p00, p01, p10, p11, u_frac, v_frac, x_edge, y_edge, mode,
           in_sol, in_eol, in_sof, out_ready,
    input  in_ready, out_valid, out_data, out_sol, out_eol, out_sof, busy
  );

  modport slave (
    input  in_valid, p00, p01, p10, p11, u_frac, v_frac, x_edge, y_edge, mode,
           in_sol, in_eol, in_sof, out_ready,
    output in_ready, out_valid, out_data, out_sol, out_eol, out_sof, busy
  );
endinterface
`default_nettype wire

// File: rtl/bilerp_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bilerp_pipe: pipelined bilinear / nearest-neighbour pixel interpolator.
// Revision 1.0
// ----------------------------------------------------------------------------
module bilerp_pipe #(
  parameter int NUM_CH     = 3,
  parameter int CH_WIDTH   = 8,
  parameter int FRAC_WIDTH = 6
) (
  input  logic         clk,
  input  logic         rst,
  bilerp_pipe_if.slave bus
);
  localparam int PIX_W = NUM_CH * CH_WIDTH;
  localparam int WW    = 2 * FRAC_WIDTH + 1;
  localparam int PW    = CH_WIDTH + WW;
  localparam int AW    = PW + 2;
  localparam int RW    = AW - 2 * FRAC_WIDTH;

  localparam logic [FRAC_WIDTH:0] c_s     = {1'b1, {FRAC_WIDTH{1'b0}}};
  localparam logic [AW-1:0]       c_round = AW'(1) << (2 * FRAC_WIDTH - 1);
  localparam logic [RW-1:0]       c_max   = {{(RW - CH_WIDTH){1'b0}}, {CH_WIDTH{1'b1}}};

  // A single advance enable keeps every stage in lockstep; bubbles are kept.
  logic w_adv;
  assign w_adv        = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = w_adv;

  // ---------------- S1: substitute taps and form weights ----------------
  logic [PIX_W-1:0]      w_x01;
  logic [PIX_W-1:0]      w_x11;
  logic [FRAC_WIDTH:0]   w_su;
  logic [FRAC_WIDTH:0]   w_sv;
  logic [FRAC_WIDTH:0]   w_uu;
  logic [FRAC_WIDTH:0]   w_vv;
  logic [PIX_W-1:0]      s1_pix_d [4];
  logic [WW-1:0]         s1_wt_d  [4];

  logic                  s1_valid_q;
  logic                  s1_mode_q;
  logic [2:0]            s1_tag_q;
  logic [1:0]            s1_sel_q;
  logic [PIX_W-1:0]      s1_pix_q [4];
  logic [WW-1:0]         s1_wt_q  [4];

  // x substitution first, so the y step copies the already-replicated top row.
  assign w_x01       = bus.x_edge ? bus.p00 : bus.p01;
  assign w_x11       = bus.x_edge ? bus.p10 : bus.p11;
  assign s1_pix_d[0] = bus.p00;
  assign s1_pix_d[1] = w_x01;
  assign s1_pix_d[2] = bus.y_edge ? bus.p00 : bus.p10;
  assign s1_pix_d[3] = bus.y_edge ? w_x01 : w_x11;

  assign w_uu       = {1'b0, bus.u_frac};
  assign w_vv       = {1'b0, bus.v_frac};
  assign w_su       = c_s - w_uu;
  assign w_sv       = c_s - w_vv;
  assign s1_wt_d[0] = WW'(w_su) * WW'(w_sv);
  assign s1_wt_d[1] = WW'(w_uu) * WW'(w_sv);
  assign s1_wt_d[2] = WW'(w_su) * WW'(w_vv);
  assign s1_wt_d[3] = WW'(w_uu) * WW'(w_vv);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_tag_q   <= '0;
      s1_sel_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        s1_pix_q[k] <= '0;
        s1_wt_q[k]  <= '0;
      end
    end else if (w_adv) begin
      s1_valid_q <= bus.in_valid;
      s1_mode_q  <= bus.mode;
      s1_tag_q   <= {bus.in_sof, bus.in_eol, bus.in_sol};
      s1_sel_q   <= {bus.v_frac[FRAC_WIDTH-1], bus.u_frac[FRAC_WIDTH-1]};
      for (int k = 0; k < 4; k++) begin
        s1_pix_q[k] <= s1_pix_d[k];
        s1_wt_q[k]  <= s1_wt_d[k];
      end
    end
  end

  // ---------------- S2: per-channel products ----------------
  logic [PW-1:0]    s2_prod_d [NUM_CH][4];
  logic [PIX_W-1:0] s2_nn_d;

  logic             s2_valid_q;
  logic             s2_mode_q;
  logic [2:0]       s2_tag_q;
  logic [PIX_W-1:0] s2_nn_q;
  logic [PW-1:0]    s2_prod_q [NUM_CH][4];

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_mul
      for (genvar k = 0; k < 4; k++) begin : g_tap
        assign s2_prod_d[c][k] = PW'(s1_pix_q[k][c*CH_WIDTH +: CH_WIDTH]) * PW'(s1_wt_q[k]);
      end
    end
  endgenerate

  // Tap index is {v MSB, u MSB}, matching the p00/p01/p10/p11 ordering.
  assign s2_nn_d = s1_pix_q[s1_sel_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_tag_q   <= '0;
      s2_nn_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 4; k++) begin
          s2_prod_q[c][k] <= '0;
        end
      end
    end else if (w_adv) begin
      s2_valid_q <= s1_valid_q;
      s2_mode_q  <= s1_mode_q;
      s2_tag_q   <= s1_tag_q;
      s2_nn_q    <= s2_nn_d;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 4; k++) begin
          s2_prod_q[c][k] <= s2_prod_d[c][k];
        end
      end
    end
  end

  // ---------------- S3: sum, round and scale ----------------
  logic [RW-1:0]    s3_sum_d [NUM_CH];

  logic             s3_valid_q;
  logic             s3_mode_q;
  logic [2:0]       s3_tag_q;
  logic [PIX_W-1:0] s3_nn_q;
  logic [RW-1:0]    s3_sum_q [NUM_CH];

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_sum
      assign s3_sum_d[c] = RW'((AW'(s2_prod_q[c][0]) + AW'(s2_prod_q[c][1]) +
                                AW'(s2_prod_q[c][2]) + AW'(s2_prod_q[c][3]) +
                                c_round) >> (2 * FRAC_WIDTH));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid_q <= 1'b0;
      s3_mode_q  <= 1'b0;
      s3_tag_q   <= '0;
      s3_nn_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        s3_sum_q[c] <= '0;
      end
    end else if (w_adv) begin
      s3_valid_q <= s2_valid_q;
      s3_mode_q  <= s2_mode_q;
      s3_tag_q   <= s2_tag_q;
      s3_nn_q    <= s2_nn_q;
      for (int c = 0; c < NUM_CH; c++) begin
        s3_sum_q[c] <= s3_sum_d[c];
      end
    end
  end

  // ---------------- Output register: saturate or pick nearest ----------------
  logic [PIX_W-1:0] out_data_d;
  logic             out_valid_q;
  logic [2:0]       out_tag_q;
  logic [PIX_W-1:0] out_data_q;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_out
      assign out_data_d[c*CH_WIDTH +: CH_WIDTH] =
          s3_mode_q              ? s3_nn_q[c*CH_WIDTH +: CH_WIDTH] :
          (s3_sum_q[c] > c_max)  ? {CH_WIDTH{1'b1}} :
                                   s3_sum_q[c][CH_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else if (w_adv) begin
      out_valid_q <= s3_valid_q;
      out_tag_q   <= s3_tag_q;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sol   = out_tag_q[0];
  assign bus.out_eol   = out_tag_q[1];
  assign bus.out_sof   = out_tag_q[2];
  assign bus.busy      = s1_valid_q | s2_valid_q | s3_valid_q | out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_bilerp_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bilerp_pipe: vector table plus scoreboard bench for bilerp_pipe.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_bilerp_pipe;
  localparam int NUM_CH     = 3;
  localparam int CH_WIDTH   = 8;
  localparam int FRAC_WIDTH = 6;
  localparam int PIX_W      = NUM_CH * CH_WIDTH;
  localparam int NVEC       = 15;

  typedef struct {
    logic [PIX_W-1:0]      p00, p01, p10, p11;
    logic [FRAC_WIDTH-1:0] u, v;
    logic                  xe, ye, mode;
    logic [2:0]            tag;
    logic [PIX_W-1:0]      exp;
  } vec_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic [2:0]       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  exp_t             sb[$];
  exp_t             cur_exp;
  exp_t             mon_e;
  logic             prev_stall = 1'b0;
  logic [PIX_W-1:0] prev_data;
  logic [2:0]       prev_tag;
  vec_t             tbl [NVEC];

  bilerp_pipe_if #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) bus ();

  bilerp_pipe #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PIX_W-1:0] act, input logic [PIX_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Independent reference: edge replication, exact weights, round to nearest.
  function automatic logic [PIX_W-1:0] model(input vec_t x);
    logic [PIX_W-1:0] t [4];
    int               w [4];
    int               su, sv, uu, vv, s, r;
    logic [PIX_W-1:0] res;
    t[0] = x.p00;
    t[1] = x.xe ? x.p00 : x.p01;
    t[2] = x.ye ? x.p00 : x.p10;
    t[3] = x.ye ? t[1] : (x.xe ? x.p10 : x.p11);
    if (x.mode) return t[{x.v[FRAC_WIDTH-1], x.u[FRAC_WIDTH-1]}];
    uu = int'(x.u);
    vv = int'(x.v);
    su = 64 - uu;
    sv = 64 - vv;
    w[0] = su * sv;
    w[1] = uu * sv;
    w[2] = su * vv;
    w[3] = uu * vv;
    res = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += int'(t[k][c*CH_WIDTH +: CH_WIDTH]) * w[k];
      r = (s + 2048) >>> 12;
      if (r > 255) r = 255;
      res[c*CH_WIDTH +: CH_WIDTH] = r[7:0];
    end
    return res;
  endfunction

  function automatic vec_t mkv(input logic [PIX_W-1:0] a, b, c, d, input int u, v,
                               input logic xe, ye, mode, input logic [PIX_W-1:0] exp);
    vec_t x;
    x.p00 = a; x.p01 = b; x.p10 = c; x.p11 = d;
    x.u = FRAC_WIDTH'(u); x.v = FRAC_WIDTH'(v);
    x.xe = xe; x.ye = ye; x.mode = mode;
    x.tag = 3'b000;
    x.exp = exp;
    return x;
  endfunction

  function automatic vec_t rnd(input logic [2:0] tag, input logic mode);
    vec_t x;
    x.p00 = PIX_W'($urandom); x.p01 = PIX_W'($urandom);
    x.p10 = PIX_W'($urandom); x.p11 = PIX_W'($urandom);
    x.u = FRAC_WIDTH'($urandom_range(0, 63));
    x.v = FRAC_WIDTH'($urandom_range(0, 63));
    x.xe = ($urandom_range(0, 3) == 0);
    x.ye = ($urandom_range(0, 3) == 0);
    x.mode = mode;
    x.tag = tag;
    x.exp = model(x);
    return x;
  endfunction

  // Scoreboard: push on transfer in, pop on transfer out, watch stalls.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
      if (prev_stall) begin
        check("stall_hold_data", bus.out_data, prev_data);
        check("stall_hold_tag", PIX_W'({bus.out_sof, bus.out_eol, bus.out_sol}), PIX_W'(prev_tag));
      end
      if (bus.out_valid && !bus.out_ready)
        check("stall_in_ready", PIX_W'(bus.in_ready), PIX_W'(0));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got pixel %h required no pixel", bus.out_data);
        end else begin
          mon_e = sb.pop_front();
          check("out_data", bus.out_data, mon_e.data);
          check("out_tag", PIX_W'({bus.out_sof, bus.out_eol, bus.out_sol}), PIX_W'(mon_e.tag));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_tag   = {bus.out_sof, bus.out_eol, bus.out_sol};
    end
  end

  task automatic send(input vec_t x);
    int   guard;
    logic acc;
    @(posedge clk); #1;
    bus.p00 = x.p00; bus.p01 = x.p01; bus.p10 = x.p10; bus.p11 = x.p11;
    bus.u_frac = x.u; bus.v_frac = x.v;
    bus.x_edge = x.xe; bus.y_edge = x.ye; bus.mode = x.mode;
    bus.in_sol = x.tag[0]; bus.in_eol = x.tag[1]; bus.in_sof = x.tag[2];
    bus.in_valid = 1'b1;
    cur_exp.data = x.exp;
    cur_exp.tag  = x.tag;
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (!acc) begin
        @(posedge clk); #1;
      end
      guard++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, required high", guard);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", PIX_W'(sb.size()), PIX_W'(0));
  endtask

  // Single pixel into an empty pipe: out_valid only after the third edge.
  task automatic lat_check(input vec_t x);
    send(x);
    idle();
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("latency_valid_edge%0d", k), PIX_W'(bus.out_valid), PIX_W'(k == 3));
    end
  endtask

  initial begin
    vec_t bp [8];
    vec_t r3 [3];
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.p00 = '0; bus.p01 = '0; bus.p10 = '0; bus.p11 = '0;
    bus.u_frac = '0; bus.v_frac = '0;
    bus.x_edge = 1'b0; bus.y_edge = 1'b0; bus.mode = 1'b0;
    bus.in_sol = 1'b0; bus.in_eol = 1'b0; bus.in_sof = 1'b0;
    cur_exp = '0;

    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", PIX_W'(bus.out_valid), PIX_W'(0));
    check("rst_out_data", bus.out_data, PIX_W'(0));
    check("rst_tags", PIX_W'({bus.out_sof, bus.out_eol, bus.out_sol}), PIX_W'(0));
    check("rst_busy", PIX_W'(bus.busy), PIX_W'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    tbl[0]  = mkv(24'h102030, PIX_W'($urandom), PIX_W'($urandom), PIX_W'($urandom), 0, 0, 0, 0, 0, 24'h102030);
    tbl[1]  = mkv(24'h000000, 24'h646464, 24'hC8C8C8, 24'hFFFFFF, 32, 32, 0, 0, 0, 24'h8B8B8B);
    tbl[2]  = mkv(24'h323232, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 63, 63, 1, 1, 0, 24'h323232);
    tbl[3]  = mkv(24'h0A0A0A, 24'hFAFAFA, 24'hFFFFFF, 24'hFFFFFF, 63, 0, 1, 0, 0, 24'h0A0A0A);
    tbl[4]  = mkv(24'h112233, 24'hABCDEF, 24'h445566, 24'h778899, 32, 31, 0, 0, 1, 24'hABCDEF);
    tbl[5]  = mkv(24'h5A1B3C, PIX_W'($urandom), PIX_W'($urandom), PIX_W'($urandom), 0, 0, 0, 0, 0, 24'h5A1B3C);
    tbl[6]  = mkv(24'h112233, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 0, 63, 0, 1, 0, 24'h112233);
    tbl[7]  = mkv(24'h000001, 24'h000000, 24'h445566, 24'h000000, 63, 63, 1, 0, 1, 24'h445566);
    tbl[8]  = mkv(24'hC0FFEE, PIX_W'($urandom), PIX_W'($urandom), PIX_W'($urandom), 31, 31, 0, 0, 1, 24'hC0FFEE);
    tbl[9]  = mkv(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 63, 63, 0, 0, 0, 24'hFFFFFF);
    tbl[10] = mkv(24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000, 63, 0, 0, 0, 0, 24'hFBFBFB);
    tbl[11] = mkv(24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000, 1, 0, 0, 0, 0, 24'h040404);
    tbl[12] = mkv(24'h000000, 24'h111111, 24'h13579B, 24'h222222, 5, 40, 0, 0, 1, 24'h13579B);
    tbl[13] = mkv(24'h2468AC, 24'h333333, 24'hFFFFFF, 24'h444444, 0, 63, 0, 1, 1, 24'h2468AC);
    tbl[14] = mkv(24'h808080, 24'h808080, 24'h808080, 24'h808080, 17, 45, 0, 0, 0, 24'h808080);
    for (int i = 0; i < NVEC; i++) tbl[i].tag = 3'(i);

    lat_check(tbl[0]);
    drain();
    for (int i = 1; i < NVEC; i++) send(tbl[i]);
    idle();
    drain();

    for (int i = 0; i < 12; i++) send(rnd(3'(i), (i % 4) == 3));
    idle();
    drain();

    for (int i = 0; i < 8; i++) bp[i] = rnd({1'b0, i == 7, i == 0}, i == 4);
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp[i]);
        idle();
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++) r3[i] = rnd(3'b000, 1'b0);
    for (int i = 0; i < 3; i++) send(r3[i]);
    idle();
    #2;
    check("busy_before_reset", PIX_W'(bus.busy), PIX_W'(1));
    rst = 1'b1;
    #1;
    check("reset_out_valid", PIX_W'(bus.out_valid), PIX_W'(0));
    check("reset_busy", PIX_W'(bus.busy), PIX_W'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale_after_reset", PIX_W'(bus.out_valid), PIX_W'(0));
    end
    lat_check(rnd(3'b100, 1'b0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bilerp_pipe.md
# bilerp_pipe

Pipelined, parametrised bilinear interpolation datapath for the scaler. It takes a four-pixel neighbourhood and the fractional coordinates (u, v) from the address/coordinate generator, and produces one interpolated output pixel per cycle. It replaces the single-cycle combinational RGB565 interpolator. New capabilities:
- arbitrary channel count and channel width;
- exact weights with round-to-nearest;
- edge replication flags;
- selectable nearest-neighbour mode;
- valid/ready backpressure, with line/frame sync flags carried alongside each pixel.

## Interface
Parameters:
- NUM_CH, 3, number of colour channels packed per pixel (channel 0 in the LSBs)
- CH_WIDTH, 8, bits per channel
- FRAC_WIDTH, 6, fractional bits of u and v; S = 2^FRAC_WIDTH

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  neighbourhood and coordinates valid
- in_ready  out  1  block accepts input this cycle
- p00, p01, p10, p11  in  NUM_CH*CH_WIDTH each  top-left, top-right, bottom-left, bottom-right pixels
- u_frac, v_frac  in  FRAC_WIDTH  horizontal and vertical fractions, 0..S-1
- x_edge  in  1  right column unavailable: replicate left column
- y_edge  in  1  bottom row unavailable: replicate top row
- mode  in  1  0 = bilinear, 1 = nearest-neighbour
- in_sol, in_eol, in_sof  in  1 each  start-of-line, end-of-line, start-of-frame tags
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts output
- out_data  out  NUM_CH*CH_WIDTH  interpolated pixel
- out_sol, out_eol, out_sof  out  1 each  tags aligned with out_data
- busy  out  1  any pipeline stage holds a valid pixel

## Operation
Stage S1 (register and substitute):
- Latch inputs. Apply edge substitution, x first, then y:
  - x_edge: p01 := p00, p11 := p10.
  - y_edge: p10 := p00, p11 := p01 (using the x-substituted values).
- Compute weights, each 2*FRAC_WIDTH+1 bits, unsigned:
  - w00 = (S-u)(S-v)
  - w01 = u(S-v)
  - w10 = (S-u)v
  - w11 = uv
- The weights always sum to S².

Stage S2 (multiply): per channel, form the four products pXY*wXY, each CH_WIDTH+2*FRAC_WIDTH+1 bits.

Stage S3 (sum and round): per channel:
- acc = Σ products + 2^(2*FRAC_WIDTH-1), with 2 guard bits.
- result = acc >> 2*FRAC_WIDTH, saturated to 2^CH_WIDTH-1.
- Saturation is unreachable for legal inputs but must be implemented.

Nearest-neighbour mode (mode=1):
- S3 outputs the substituted pixel selected by {v_frac MSB, u_frac MSB}: 00→p00, 01→p01, 10→p10, 11→p11.
- Arithmetic results are discarded.

Per-pixel attributes:
- mode, the sync tags and the valid bit travel with each pixel through every stage. Mode may change pixel to pixel.
- Pixels are never reordered, dropped or duplicated.

## Timing
- Handshake:
  - adv = out_ready | ~out_valid.
  - in_ready = adv (combinational).
  - Transfer happens on in_valid & in_ready.
  - All stages advance together when adv = 1 and hold when adv = 0.
  - Bubbles are not compressed.
- Latency: 3 cycles. A pixel accepted at edge N appears with out_valid=1 after edge N+3 when out_ready stays high.
- Throughput: 1 pixel/clk when sustained.
- While out_valid=1 and out_ready=0:
  - out_data and the tags are held stable;
  - in_ready=0.
- Reset values: out_valid=0, out_data=0, out_sol/out_eol/out_sof=0, busy=0, all internal valid bits 0.
- Reset asserted mid-stream discards every in-flight pixel immediately (asynchronous). The first pixel accepted after release emerges 3 cycles later.
- u=v=0 yields exactly p00 (w00=S²). No u/v values outside 0..S-1 are possible, so no wrap handling is needed.
- Simultaneous x_edge and y_edge: all four taps equal p00.

## Test plan
1. Bilinear, u=v=0, p00=0x10_20_30, others random, out_ready=1 → out_data=0x102030 exactly 3 cycles after acceptance, out_valid for 1 cycle.
2. Rounding, u=v=32, per channel p00=0, p01=100, p10=200, p11=255 → each channel = 139 (555/4=138.75 rounded).
3. Edges, x_edge=y_edge=1, u=v=63, p00=50 per channel, others 255 → every channel = 50; x_edge only, v=0, u=63, p00=10, p01=250 → 10.
4. Nearest, mode=1, u=32, v=31 → out_data=p01; next pixel mode=0 with u=v=0 → p00, with no pipeline flush between them.
5. Backpressure: stream 8 pixels tagged sol on #0 and eol on #7, drop out_ready for 5 cycles mid-stream → all 8 emerge in order with correct tags, out_data stable while stalled, in_ready=0 throughout the stall.
6. Reset mid-stream with 3 pixels in flight → out_valid=0 and busy=0 immediately, no stale pixel after release, next pixel latency 3.
